// File: rtl/move_sequencer.sv
// Whole-move sequencer for the XY gantry: buffers compass steps, optionally homes,
// drives the electromagnet and hands one-hot step pulses to the motor block.
module move_sequencer #(
    parameter int unsigned DEPTH          = 16,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned CNT_W          = 24,
    parameter int unsigned SETTLE_CYCLES  = 50000,
    parameter int unsigned GAP_CYCLES     = 5000,
    parameter int unsigned TIMEOUT_CYCLES = 10000000
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            step_valid,
    input  logic [2:0]      step_dir,
    output logic            step_ready,
    input  logic            start,
    input  logic            home_first,
    input  logic            abort,
    input  logic            motor_done,
    output logic [7:0]      direction,
    output logic            home,
    output logic            magnet_en,
    output logic            busy,
    output logic            seq_done,
    output logic            error,
    output logic [ADDR_W:0] level
);

    typedef enum logic [3:0] {
        IDLE, HOME, HOME_WAIT, MAG_ON, ISSUE, WAIT_DONE, GAP, MAG_OFF, FINISH, ABORT_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_C  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] GAP_C     = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [ADDR_W:0]  FULL_C    = (ADDR_W+1)'(DEPTH);

    state_t            state;
    logic [2:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  cnt, cnt_inc;
    logic              armed, pending, push;

    // armed keeps step_ready low while reset is held, so every output reads 0 in reset
    assign step_ready = armed && (state == IDLE) && (level != FULL_C);
    assign push       = step_valid && step_ready;
    assign busy       = (state != IDLE);
    assign cnt_inc    = (&cnt) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= step_dir;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            cnt       <= '0;
            armed     <= 1'b0;
            pending   <= 1'b0;
            direction <= '0;
            home      <= 1'b0;
            magnet_en <= 1'b0;
            seq_done  <= 1'b0;
            error     <= 1'b0;
        end else begin
            armed     <= 1'b1;
            cnt       <= cnt_inc;
            direction <= '0;
            home      <= 1'b0;
            seq_done  <= 1'b0;
            if (motor_done) pending <= 1'b0;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                level  <= level + 1'b1;
            end

            if (abort && state != IDLE) begin
                state     <= ABORT_WAIT;
                cnt       <= '0;
                magnet_en <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (abort) begin
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                            level  <= '0;
                        end else if (start) begin
                            error <= 1'b0;
                            cnt   <= '0;
                            if (home_first) begin
                                state   <= HOME;
                                home    <= 1'b1;
                                pending <= 1'b1;
                            end else if (level == '0) begin
                                state    <= FINISH;
                                seq_done <= 1'b1;
                            end else begin
                                state     <= MAG_ON;
                                magnet_en <= 1'b1;
                            end
                        end
                    end
                    HOME: begin
                        state <= HOME_WAIT;
                        cnt   <= '0;
                    end
                    HOME_WAIT, WAIT_DONE: begin
                        if (motor_done) begin
                            cnt <= '0;
                            if (level == '0) begin
                                if (state == HOME_WAIT) begin
                                    state    <= FINISH;
                                    seq_done <= 1'b1;
                                end else begin
                                    state     <= MAG_OFF;
                                    magnet_en <= 1'b0;
                                end
                            end else if (state == HOME_WAIT) begin
                                state     <= MAG_ON;
                                magnet_en <= 1'b1;
                            end else begin
                                state <= GAP;
                            end
                        end else if (cnt >= TIMEOUT_C) begin
                            state     <= IDLE;
                            error     <= 1'b1;
                            magnet_en <= 1'b0;
                            pending   <= 1'b0;
                            wr_ptr    <= '0;
                            rd_ptr    <= '0;
                            level     <= '0;
                        end
                    end
                    MAG_ON: begin
                        if (cnt >= SETTLE_C) begin
                            state <= ISSUE;
                            cnt   <= '0;
                        end
                    end
                    ISSUE: begin
                        if (!motor_done) begin
                            direction <= 8'b1 << mem[rd_ptr];
                            rd_ptr    <= rd_ptr + 1'b1;
                            level     <= level - 1'b1;
                            pending   <= 1'b1;
                            state     <= WAIT_DONE;
                            cnt       <= '0;
                        end
                    end
                    GAP: begin
                        if (cnt >= GAP_C) begin
                            state <= ISSUE;
                            cnt   <= '0;
                        end
                    end
                    MAG_OFF: begin
                        if (cnt >= SETTLE_C) begin
                            state    <= FINISH;
                            seq_done <= 1'b1;
                            cnt      <= '0;
                        end
                    end
                    FINISH: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                    ABORT_WAIT: begin
                        // a move still in flight must finish (or time out) before the path is dropped
                        if (!pending || motor_done || cnt >= TIMEOUT_C) begin
                            state   <= IDLE;
                            pending <= 1'b0;
                            wr_ptr  <= '0;
                            rd_ptr  <= '0;
                            level   <= '0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_move_sequencer.sv
// Self-checking bench for move_sequencer: vector table of single steps, scoreboard of
// expected direction pulses, and hand-written multi-cycle corner sequences.
module tb_move_sequencer;

    localparam int SETTLE  = 20;
    localparam int GAPC    = 8;
    localparam int TIMEOUT = 1000;
    localparam int DEPTH   = 16;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       step_valid = 1'b0;
    logic [2:0] step_dir = '0;
    logic       step_ready;
    logic       start = 1'b0;
    logic       home_first = 1'b0;
    logic       abort = 1'b0;
    logic       motor_done = 1'b0;
    logic [7:0] direction;
    logic       home, magnet_en, busy, seq_done, error;
    logic [4:0] level;

    move_sequencer #(
        .DEPTH(16), .ADDR_W(4), .CNT_W(24),
        .SETTLE_CYCLES(SETTLE), .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .step_valid(step_valid), .step_dir(step_dir),
        .step_ready(step_ready), .start(start), .home_first(home_first), .abort(abort),
        .motor_done(motor_done), .direction(direction), .home(home), .magnet_en(magnet_en),
        .busy(busy), .seq_done(seq_done), .error(error), .level(level)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int cyc = 0, pulse_cnt = 0, home_cnt = 0, done_cnt = 0, pulse_cyc = 0;
    bit motor_hang = 1'b0;
    bit magnet_seen = 1'b0;
    int motor_delay = 20;
    int mdl_level = 0;
    logic [7:0] exp_q[$];
    logic [7:0] dir_code[8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    typedef struct {
        logic [2:0] dir;
        logic [7:0] exp_dir;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Motor model and output monitor: pops the scoreboard on every pulse.
    initial begin
        int timer;
        timer = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            motor_done = 1'b0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) motor_done = 1'b1;
            end
            if (magnet_en) magnet_seen = 1'b1;
            if (seq_done) done_cnt++;
            if (direction != 8'h00) begin
                pulse_cnt++;
                pulse_cyc = cyc;
                check("dir_onehot", 32'($onehot(direction)), 1);
                check("home_during_dir", home, 0);
                check("magnet_at_pulse", magnet_en, 1);
                if (exp_q.size() == 0) check("unexpected_pulse", direction, 0);
                else check("dir_value", direction, exp_q.pop_front());
                if (!motor_hang) timer = motor_delay;
            end
            if (home) begin
                home_cnt++;
                check("dir_during_home", direction, 0);
                if (!motor_hang) timer = motor_delay;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_step(input logic [2:0] d, input logic [7:0] exp);
        step_dir = d;
        step_valid = 1'b1;
        tick();
        step_valid = 1'b0;
        if (mdl_level < DEPTH) begin
            exp_q.push_back(exp);
            mdl_level++;
        end
    endtask

    task automatic do_start(input logic hf);
        start = 1'b1;
        home_first = hf;
        tick();
        start = 1'b0;
        home_first = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(name, busy, 0);
    endtask

    task automatic flush_model();
        exp_q.delete();
        mdl_level = 0;
    endtask

    initial begin
        int p0, d0, h0, c0, dly, n;
        vecs[0] = '{3'd0, 8'h01}; vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04}; vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10}; vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40}; vecs[7] = '{3'd7, 8'h80};

        #1;
        check("rst_direction", direction, 0);
        check("rst_home", home, 0);
        check("rst_magnet", magnet_en, 0);
        check("rst_busy", busy, 0);
        check("rst_seq_done", seq_done, 0);
        check("rst_error", error, 0);
        check("rst_level", level, 0);
        check("rst_step_ready", step_ready, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick();
        check("ready_after_reset", step_ready, 1);

        // single-step paths, one per compass direction
        for (int i = 0; i < 8; i++) begin
            push_step(vecs[i].dir, vecs[i].exp_dir);
            check("vec_level", level, 1);
            p0 = pulse_cnt; d0 = done_cnt;
            do_start(1'b0);
            c0 = cyc;
            wait_idle(400, "vec_idle");
            check("vec_pulses", pulse_cnt - p0, 1);
            check("vec_seq_done", done_cnt - d0, 1);
            check("vec_magnet_off", magnet_en, 0);
            check("vec_level_end", level, 0);
            if (i == 0) check("start_to_pulse_latency", pulse_cyc - c0, SETTLE + 2);
            mdl_level = 0;
        end

        // N, E, NE path
        push_step(3'd0, dir_code[0]);
        push_step(3'd6, dir_code[6]);
        push_step(3'd7, dir_code[7]);
        check("path3_level", level, 3);
        p0 = pulse_cnt; d0 = done_cnt;
        do_start(1'b0);
        wait_idle(600, "path3_idle");
        check("path3_pulses", pulse_cnt - p0, 3);
        check("path3_seq_done", done_cnt - d0, 1);
        check("path3_magnet_off", magnet_en, 0);
        check("path3_queue_empty", exp_q.size(), 0);
        mdl_level = 0;

        // homing with an empty path: magnet must stay off throughout
        magnet_seen = 1'b0;
        p0 = pulse_cnt; d0 = done_cnt; h0 = home_cnt;
        do_start(1'b1);
        wait_idle(200, "home_idle");
        check("home_pulses", home_cnt - h0, 1);
        check("home_no_dir", pulse_cnt - p0, 0);
        check("home_seq_done", done_cnt - d0, 1);
        check("home_magnet_never", magnet_seen, 0);

        // fill past capacity
        for (int i = 0; i < DEPTH; i++) push_step(3'(i % 8), dir_code[i % 8]);
        check("full_level", level, DEPTH);
        check("full_not_ready", step_ready, 0);
        push_step(3'd3, dir_code[3]);
        check("overflow_dropped", level, DEPTH);
        p0 = pulse_cnt; d0 = done_cnt;
        do_start(1'b0);
        wait_idle(3000, "full_idle");
        check("full_pulses", pulse_cnt - p0, DEPTH);
        check("full_queue_empty", exp_q.size(), 0);
        check("full_seq_done", done_cnt - d0, 1);
        mdl_level = 0;

        // watchdog: motor never answers
        motor_hang = 1'b1;
        push_step(3'd4, dir_code[4]);
        push_step(3'd2, dir_code[2]);
        p0 = pulse_cnt; d0 = done_cnt;
        do_start(1'b0);
        n = 0;
        while (pulse_cnt == p0 && n < 100) begin tick(); n++; end
        check("wd_first_pulse", pulse_cnt - p0, 1);
        n = 0;
        while (!error && n < TIMEOUT + 50) begin tick(); n++; end
        check("wd_error", error, 1);
        dly = cyc - pulse_cyc;
        check("wd_delay_in_window", (dly >= TIMEOUT && dly <= TIMEOUT + 2), 1);
        check("wd_magnet_off", magnet_en, 0);
        check("wd_level", level, 0);
        check("wd_busy", busy, 0);
        check("wd_no_seq_done", done_cnt - d0, 0);
        flush_model();
        tick(); tick();
        check("wd_error_sticky", error, 1);
        motor_hang = 1'b0;
        do_start(1'b0);
        check("wd_start_clears", error, 0);
        wait_idle(50, "wd_restart_idle");

        // abort while in the inter-step gap of a 5-step path
        for (int i = 0; i < 5; i++) push_step(3'(i), dir_code[i]);
        p0 = pulse_cnt; d0 = done_cnt;
        do_start(1'b0);
        n = 0;
        while (pulse_cnt == p0 && n < 100) begin tick(); n++; end
        c0 = pulse_cyc;
        n = 0;
        while (cyc < c0 + motor_delay + 3 && n < 100) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_magnet_next", magnet_en, 0);
        flush_model();
        wait_idle(50, "abort_idle");
        check("abort_level", level, 0);
        for (int i = 0; i < 60; i++) tick();
        check("abort_pulses", pulse_cnt - p0, 1);
        check("abort_no_seq_done", done_cnt - d0, 0);

        // abort and start together in IDLE: abort wins
        push_step(3'd1, dir_code[1]);
        push_step(3'd5, dir_code[5]);
        p0 = pulse_cnt;
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        flush_model();
        check("abort_start_busy", busy, 0);
        check("abort_start_level", level, 0);
        for (int i = 0; i < SETTLE + 10; i++) tick();
        check("abort_start_no_pulse", pulse_cnt - p0, 0);

        // asynchronous reset in the middle of WAIT_DONE
        motor_hang = 1'b1;
        for (int i = 0; i < 3; i++) push_step(3'd6, dir_code[6]);
        p0 = pulse_cnt;
        do_start(1'b0);
        n = 0;
        while (pulse_cnt == p0 && n < 100) begin tick(); n++; end
        tick(); tick(); tick();
        reset_n = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_magnet", magnet_en, 0);
        check("arst_level", level, 0);
        check("arst_step_ready", step_ready, 0);
        check("arst_direction", direction, 0);
        check("arst_error", error, 0);
        flush_model();
        motor_hang = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("arst_release_level", level, 0);
        check("arst_release_ready", step_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
